// File: rtl/axi_w_pkg.sv
// Shared types for the AXI write-data driver: beat payload layout and widths.
package axi_w_pkg;

    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

    // One write-data beat as stored in the buffer and presented on the W channel.
    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_STRB_W-1:0] strb;
        logic                  last;
    } w_beat_t;

endpackage

// File: rtl/axi_w_fifo.sv
// Synchronous FIFO of write beats with an explicit occupancy count.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   push_i       - write wr_beat_i at the rising edge (ignored when full)
//   pop_i        - drop the head entry at the rising edge (ignored when empty)
//   wr_beat_i    - beat to store
//   rd_beat_o    - current head entry (undefined content when empty)
//   level_o      - number of stored beats, 0..DEPTH
module axi_w_fifo
    import axi_w_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  w_beat_t                    wr_beat_i,
    output w_beat_t                    rd_beat_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    w_beat_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               do_push, do_pop;

    assign do_push = push_i && (level_q != LVL_W'(DEPTH));
    assign do_pop  = pop_i && (level_q != '0);

    // Pointer and level next-state; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: entries are only observed once level covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_beat_i;
    end

    assign rd_beat_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;

endmodule

// File: rtl/axi_wdata_driver.sv
// Manager-side AXI W channel source: buffers local beats, drives wvalid/wdata/
// wstrb/wlast, and flags wvalid waiting too long for wready.
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   in_valid/in_ready               - local beat handshake
//   in_data/in_strb/in_last         - local beat payload
//   wvalid/wready                   - AXI W handshake
//   wdata/wstrb/wlast               - AXI W payload (zero when buffer empty)
//   level                           - buffered beat count
//   stall_cnt                       - consecutive stalled cycles, saturating
//   stall_err / clr_err             - sticky stall-limit flag and its clear
module axi_wdata_driver
    import axi_w_pkg::*;
#(
    parameter int unsigned DATA_W    = AXI_DATA_W,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_STALL = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_data,
    input  logic [DATA_W/8-1:0]            in_strb,
    input  logic                           in_last,
    output logic                           wvalid,
    input  logic                           wready,
    output logic [DATA_W-1:0]              wdata,
    output logic [DATA_W/8-1:0]            wstrb,
    output logic                           wlast,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic [$clog2(MAX_STALL+2)-1:0] stall_cnt,
    output logic                           stall_err,
    input  logic                           clr_err
);

    localparam int unsigned LVL_W   = $clog2(DEPTH + 1);
    localparam int unsigned STALL_W = $clog2(MAX_STALL + 2);
    localparam int unsigned STRB_W  = DATA_W / 8;

    w_beat_t             in_beat;
    w_beat_t             head_beat;
    logic [LVL_W-1:0]    level_w;
    logic                push, pop, stalled;
    logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic                stall_err_q, stall_err_d;

    assign in_beat.data = AXI_DATA_W'(in_data);
    assign in_beat.strb = AXI_STRB_W'(in_strb);
    assign in_beat.last = in_last;

    // No full-bypass: a pop in the same cycle does not reopen in_ready.
    assign in_ready = (level_w != LVL_W'(DEPTH));
    assign wvalid   = (level_w != '0);
    assign push     = in_valid && in_ready;
    assign pop      = wvalid && wready;
    assign stalled  = wvalid && !wready;

    axi_w_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .pop_i     (pop),
        .wr_beat_i (in_beat),
        .rd_beat_o (head_beat),
        .level_o   (level_w)
    );

    // Head only moves on a pop, so the payload is stable while stalled.
    assign wdata = wvalid ? DATA_W'(head_beat.data) : '0;
    assign wstrb = wvalid ? STRB_W'(head_beat.strb) : '0;
    assign wlast = wvalid && head_beat.last;
    assign level = level_w;

    // Stall counter saturates at MAX_STALL+1; error sets when that value is reached
    // and a same-edge violation overrides clr_err.
    always_comb begin
        stall_cnt_d = '0;
        stall_err_d = stall_err_q;
        if (clr_err) stall_err_d = 1'b0;
        if (stalled) begin
            if (stall_cnt_q != STALL_W'(MAX_STALL + 1)) begin
                stall_cnt_d = stall_cnt_q + STALL_W'(1);
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (stall_cnt_q >= STALL_W'(MAX_STALL)) stall_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign stall_err = stall_err_q;

endmodule

// File: doc/axi_wdata_driver.md
Name: axi_wdata_driver

Overview:
- Manager-side AXI write-data channel source that buffers write beats from the local datapath and drives wvalid/wdata/wstrb/wlast toward the subordinate.
- Sits directly upstream of the wvalid/wready handshake checked by the write-channel assertions. It enforces the AXI rule that wvalid, once raised, stays high with stable payload until wready.
- Internally measures how long wvalid waits without wready and raises a sticky error when the wait exceeds MAX_STALL cycles.

Parameters:
- DATA_W, 32, width of wdata in bits; wstrb is DATA_W/8 bits.
- DEPTH, 4, beat buffer entries; power of two, at least 2.
- MAX_STALL, 2, maximum consecutive cycles wvalid may be high without wready.

Ports:
- clk  in  1  single clock; all logic updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  local beat offered.
- in_ready  out  1  local beat accepted when in_valid && in_ready.
- in_data  in  DATA_W  beat data.
- in_strb  in  DATA_W/8  beat byte strobes.
- in_last  in  1  last beat of burst.
- wvalid  out  1  AXI write-data valid.
- wready  in  1  AXI write-data ready.
- wdata  out  DATA_W  AXI write data.
- wstrb  out  DATA_W/8  AXI write strobes.
- wlast  out  1  AXI write last.
- level  out  $clog2(DEPTH+1)  buffered beat count.
- stall_cnt  out  $clog2(MAX_STALL+2)  current consecutive stall cycles, saturating at MAX_STALL+1.
- stall_err  out  1  sticky stall-limit violation flag.
- clr_err  in  1  clears stall_err.

Behaviour:
- Reset (rst=1 at a clk edge):
  - level=0, wvalid=0, wdata/wstrb/wlast=0, stall_cnt=0, stall_err=0, in_ready=1 on the following cycle.
  - Reset mid-burst discards all buffered beats with no handshake.
- Push:
  - A push occurs at an edge with in_valid && in_ready.
  - in_ready = (level != DEPTH), derived combinationally from registered level.
  - When full, in_ready=0 even if a pop occurs in the same cycle. There is no full-bypass.
- Pop:
  - A pop occurs at an edge with wvalid && wready.
  - wvalid = (level != 0). wdata/wstrb/wlast always show the oldest entry and are zero when empty.
- Latency: a beat pushed at edge N is visible on wvalid at the cycle after edge N. There is no combinational in-to-w bypass.
- Simultaneous push and pop with 0<level<DEPTH: level unchanged, order preserved.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. level is tracked explicitly from 0 to DEPTH.
- AXI stability: while wvalid && !wready, the payload must not change. This is guaranteed because the head entry changes only on a pop.
- Stall counter:
  - If wvalid && !wready: stall_cnt <= min(stall_cnt+1, MAX_STALL+1).
  - Otherwise (handshake or wvalid=0): stall_cnt <= 0.
- Error:
  - stall_err <= 1 at the edge where stall_cnt would become MAX_STALL+1, i.e. the (MAX_STALL+1)-th consecutive stalled cycle.
  - Once set, stall_err holds until rst or clr_err. If clr_err and a new violation occur at the same edge, set wins.
- wlast: carried opaquely from in_last. The block does not count burst length.

Decomposition:
- Package axi_w_pkg:
  - typedef struct packed w_beat_t {data, strb, last}, parameterised through DATA_W localparams.
  - Constant AXI_STRB_W = DATA_W/8.
- One sub-module, axi_w_fifo: a synchronous FIFO of w_beat_t (DEPTH entries, level output).
- The top level adds the handshake mapping, stall counter and error flag.

Test Plan:
- Reset then single beat: push data=0xA5A5_0001, strb=0xF, last=1 with wready=1.
  - Required: wvalid=1 exactly one cycle after the push edge, handshake on that cycle, then level=0, wvalid=0, stall_err=0.
- Fill: wready=0, push 4 beats 0x10..0x13.
  - Required: level=4, in_ready=0, a 5th in_valid is not accepted.
  - Then wready=1 for 4 cycles: wdata drains as 0x10,0x11,0x12,0x13 in order.
- Stall limit, MAX_STALL=2: hold one beat with wready=0.
  - Required: stall_cnt counts 1, 2, 3. stall_err rises at the edge of the 3rd stalled cycle and stays 1 after wready=1.
  - Required: wdata stays constant throughout the stall.
- Non-violation: wready low for exactly 2 cycles, then high.
  - Required: stall_cnt is 1, 2, then 0, and stall_err stays 0.
- Simultaneous push/pop at level=2 with wready=1 for 6 cycles and continuous pushes.
  - Required: level stays 2 and the output sequence matches the input sequence exactly.
- Reset mid-operation: level=3 with stall_err=1, assert rst for one edge.
  - Required: level=0, wvalid=0, stall_err=0, in_ready=1. A subsequent beat emerges with correct data.
